// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC owner and fetch sequencer with a 2-entry fetch queue.
// Issues one outstanding imem request at a time, applies PcSel/BrPC redirects.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   PcSel, BrPC           redirect request and target from the branch unit
//   stall                 downstream hold; head consumed when if_valid && !stall
//   imem_req, imem_addr   request strobe and address
//   imem_rvalid/rdata     response strobe and instruction
//   if_valid/pc/instr     fetch queue head
//   misalign_trap/trap_pc (FETCH_MISALIGN_TRAP_EN only) sticky misaligned-target trap
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on BrPC[1:0] != 0.
module fetch_redirect_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_trap,
    output logic [31:0]     trap_pc,
`endif
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] tgt;
    logic [1:0]      cnt;
    logic [1:0]      cnt_nxt;
    logic [1:0]      occ;
    entry_t          q0;
    entry_t          q1;
    entry_t          q0_nxt;
    entry_t          q1_nxt;
    entry_t          new_ent;
    logic            pop;
    logic            push;
    logic            flush;
    logic            req;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misal;
    logic            trap_set;

    assign misal = (BrPC[1:0] != 2'b00);
    assign tgt   = BrPC[PC_W-1:0];
`else
    logic            brpc_unused;

    // Low two bits are dropped so the PC stays word aligned.
    assign tgt         = {BrPC[PC_W-1:2], 2'b00};
    assign brpc_unused = ^BrPC;
`endif

    assign pop     = (cnt != 2'd0) && !stall;
    assign occ     = cnt - {1'b0, pop};
    assign new_ent = '{pc: pc, instr: imem_rdata};

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req       = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                req = (occ < 2'd2);
                if (req) begin
                    state_nxt = S_WAIT;
                end
                if (PcSel) begin
                    flush     = 1'b1;
                    pc_nxt    = tgt;
                    // An issued request is still owed a response.
                    state_nxt = req ? S_DRAIN : S_FETCH;
                end
            end
            S_WAIT: begin
                if (PcSel) begin
                    flush     = 1'b1;
                    pc_nxt    = tgt;
                    state_nxt = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    push      = 1'b1;
                    pc_nxt    = pc + PC_W'(4);
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (PcSel) begin
                    flush  = 1'b1;
                    pc_nxt = tgt;
                end
                // The stale response retires the old request.
                if (imem_rvalid) begin
                    state_nxt = S_FETCH;
                end
            end
            S_TRAP: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_nxt = S_TRAP;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_set = flush && misal;
        if (trap_set) begin
            pc_nxt    = pc;
            state_nxt = S_TRAP;
        end
`endif
    end

    always_comb begin
        q0_nxt  = q0;
        q1_nxt  = q1;
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = 2'd0;
        end else begin
            if (pop) begin
                q0_nxt = q1;
            end
            if (push) begin
                unique case (1'b1)
                    (occ == 2'd0): q0_nxt = new_ent;
                    default:       q1_nxt = new_ent;
                endcase
            end
            cnt_nxt = occ + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            cnt   <= 2'd0;
            q0    <= '{pc: '0, instr: NOP};
            q1    <= '{pc: '0, instr: NOP};
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            q0    <= q0_nxt;
            q1    <= q1_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap <= 1'b0;
            trap_pc       <= '0;
        end else if (trap_set) begin
            misalign_trap <= 1'b1;
            trap_pc       <= BrPC;
        end
    end
`endif

    assign imem_req  = req;
    assign imem_addr = req ? pc : '0;
    assign if_valid  = (cnt != 2'd0);
    assign if_pc     = q0.pc;
    assign if_instr  = q0.instr;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed bench for fetch_redirect_unit.
// Memory model answers each request a programmable number of cycles later.
module tb_fetch_redirect_unit;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = '0;
    logic            stall = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_trap;
    logic [31:0]     trap_pc;
`endif

    int lat = 1;
    int n_vec = 0;
    int n_bad = 0;

    fetch_redirect_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
        .trap_pc      (trap_pc),
`endif
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int pend;
        logic [PC_W-1:0] a;
        pend = 0;
        a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                imem_rvalid = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = dat(a);
                    end
                end
                #1;
                if (rst_n && imem_req) begin
                    pend = lat;
                    a    = imem_addr;
                end
            end
        end
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        PcSel = 1'b0;
        BrPC  = '0;
        #2;
        check({tag, ".rst_req"}, imem_req, 0);
        check({tag, ".rst_addr"}, imem_addr, 0);
        check({tag, ".rst_v"}, if_valid, 0);
        check({tag, ".rst_pc"}, if_pc, 0);
        check({tag, ".rst_instr"}, if_instr, 32'h13);
`ifdef FETCH_MISALIGN_TRAP_EN
        check({tag, ".rst_trap"}, misalign_trap, 0);
        check({tag, ".rst_tpc"}, trap_pc, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check({tag, ".idle_req"}, imem_req, 0);
        check({tag, ".idle_v"}, if_valid, 0);
    endtask

    task automatic step(input logic st, input logic ps,
                        input logic [31:0] br, input logic er,
                        input logic [PC_W-1:0] ea, input logic ev,
                        input logic [PC_W-1:0] ep, input string tag);
        @(negedge clk);
        stall = st;
        PcSel = ps;
        BrPC  = br;
        #2;
        check({tag, ".req"}, imem_req, er);
        if (er) check({tag, ".addr"}, imem_addr, ea);
        check({tag, ".v"}, if_valid, ev);
        if (ev) begin
            check({tag, ".pc"}, if_pc, ep);
            check({tag, ".instr"}, if_instr, dat(ep));
        end
    endtask

    initial begin
        lat = 1;
        do_reset("t1");
        step(0, 0, 0, 1, 'h000, 0, 0,     "t1c1");
        step(0, 0, 0, 0, 0,     0, 0,     "t1c2");
        step(0, 0, 0, 1, 'h004, 1, 'h000, "t1c3");
        step(0, 0, 0, 0, 0,     0, 0,     "t1c4");
        step(0, 0, 0, 1, 'h008, 1, 'h004, "t1c5");
        step(0, 0, 0, 0, 0,     0, 0,     "t1c6");
        step(0, 0, 0, 1, 'h00C, 1, 'h008, "t1c7");

        do_reset("t2");
        step(1, 0, 0, 1, 'h000, 0, 0,     "t2c1");
        step(1, 0, 0, 0, 0,     0, 0,     "t2c2");
        step(1, 0, 0, 1, 'h004, 1, 'h000, "t2c3");
        step(1, 0, 0, 0, 0,     1, 'h000, "t2c4");
        step(1, 0, 0, 0, 0,     1, 'h000, "t2c5");
        step(1, 0, 0, 0, 0,     1, 'h000, "t2c6");
        step(0, 0, 0, 1, 'h008, 1, 'h000, "t2c7");
        step(0, 0, 0, 0, 0,     1, 'h004, "t2c8");
        step(0, 0, 0, 1, 'h00C, 1, 'h008, "t2c9");

        lat = 3;
        do_reset("t3");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t3c1");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c2");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c3");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c4");
        step(0, 0, 0,     1, 'h004, 1, 'h000, "t3c5");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c6");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c7");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c8");
        step(0, 0, 0,     1, 'h008, 1, 'h004, "t3c9");
        step(0, 1, 'h040, 0, 0,     0, 0,     "t3c10");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c11");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c12");
        step(0, 0, 0,     1, 'h040, 0, 0,     "t3c13");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c14");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c15");
        step(0, 0, 0,     0, 0,     0, 0,     "t3c16");
        step(0, 0, 0,     1, 'h044, 1, 'h040, "t3c17");

        lat = 1;
        do_reset("t4");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t4c1");
        step(0, 1, 'h080, 0, 0,     0, 0,     "t4c2");
        step(0, 0, 0,     1, 'h080, 0, 0,     "t4c3");
        step(0, 0, 0,     0, 0,     0, 0,     "t4c4");
        step(0, 0, 0,     1, 'h084, 1, 'h080, "t4c5");

        do_reset("t5");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t5c1");
        step(0, 1, 'h1FC, 0, 0,     0, 0,     "t5c2");
        step(0, 0, 0,     1, 'h1FC, 0, 0,     "t5c3");
        step(0, 0, 0,     0, 0,     0, 0,     "t5c4");
        step(0, 0, 0,     1, 'h000, 1, 'h1FC, "t5c5");

        do_reset("t6");
        step(1, 0, 0,     1, 'h000, 0, 0,     "t6c1");
        step(1, 0, 0,     0, 0,     0, 0,     "t6c2");
        step(1, 0, 0,     1, 'h004, 1, 'h000, "t6c3");
        step(1, 0, 0,     0, 0,     1, 'h000, "t6c4");
        step(1, 1, 'h100, 0, 0,     1, 'h000, "t6c5");
        step(1, 0, 0,     1, 'h100, 0, 0,     "t6c6");
        step(1, 0, 0,     0, 0,     0, 0,     "t6c7");
        step(1, 0, 0,     1, 'h104, 1, 'h100, "t6c8");

        lat = 2;
        do_reset("t7");
        step(0, 1, 'h020, 1, 'h000, 0, 0,     "t7c1");
        step(0, 1, 'h030, 0, 0,     0, 0,     "t7c2");
        step(0, 0, 0,     0, 0,     0, 0,     "t7c3");
        step(0, 0, 0,     1, 'h030, 0, 0,     "t7c4");
        step(0, 0, 0,     0, 0,     0, 0,     "t7c5");
        step(0, 0, 0,     0, 0,     0, 0,     "t7c6");
        step(0, 0, 0,     1, 'h034, 1, 'h030, "t7c7");

        lat = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        do_reset("t8");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t8c1");
        step(0, 0, 0,     0, 0,     0, 0,     "t8c2");
        step(0, 0, 0,     1, 'h004, 1, 'h000, "t8c3");
        step(0, 1, 'h042, 0, 0,     0, 0,     "t8c4");
        step(0, 0, 0,     0, 0,     0, 0,     "t8c5");
        check("t8.trap", misalign_trap, 1);
        check("t8.tpc", trap_pc, 32'h42);
        step(0, 1, 'h080, 0, 0,     0, 0,     "t8c6");
        step(0, 0, 0,     0, 0,     0, 0,     "t8c7");
        step(0, 0, 0,     0, 0,     0, 0,     "t8c8");
        check("t8.trap2", misalign_trap, 1);
        check("t8.tpc2", trap_pc, 32'h42);
        do_reset("t8r");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t8r1");
`else
        do_reset("t8");
        step(0, 0, 0,     1, 'h000, 0, 0,     "t8c1");
        step(0, 1, 'h0A3, 0, 0,     0, 0,     "t8c2");
        step(0, 0, 0,     1, 'h0A0, 0, 0,     "t8c3");
        step(0, 0, 0,     0, 0,     0, 0,     "t8c4");
        step(0, 0, 0,     1, 'h0A4, 1, 'h0A0, "t8c5");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
